// File: rtl/miner_work_feeder.sv
// rtl/miner_work_feeder.sv - host-side work loader and result reporter for the serial miner port
//
// Takes one 352-bit work unit {midstate[255:0], header tail[95:0]} over valid/ready and
// shifts it into the miner as 11 32-bit words, most significant word first, while
// miner_ready is high. Then it watches the miner's sticky hit flag. It returns either the
// golden nonce or an "exhausted" result over valid/ready.
//
// Build option: define NONCE_CORR_EN to report miner_serial_out - NONCE_OFFSET instead of
// the raw miner nonce.
//
// Ports:
//   hash_clk          clock
//   rst_n             synchronous reset, active-low
//   work_valid        work unit offered
//   work_ready        work unit accepted when work_valid & work_ready (combinational)
//   work_data[351:0]  [351:96] midstate, [95:0] header tail
//   miner_ready       miner load strobe; also clears/restarts the miner
//   miner_serial_in   word shifted into the miner while miner_ready=1
//   miner_hit         miner sticky hit flag
//   miner_serial_out  miner nonce, valid while miner_hit=1
//   result_valid      result held until accepted
//   result_ready      result consumer ready
//   result_found      1 = golden nonce found, 0 = nonce space exhausted
//   result_nonce      reported nonce; 0 when result_found=0
//   busy              state != IDLE

module miner_work_feeder #(
   parameter int unsigned LOOP_LOG2    = 0,
   parameter logic [39:0] SCAN_CYCLES  = (40'd1 << 32) << LOOP_LOG2,
   parameter logic [31:0] NONCE_OFFSET = 32'd131
) (
   input  logic         hash_clk,
   input  logic         rst_n,
   input  logic         work_valid,
   output logic         work_ready,
   input  logic [351:0] work_data,
   output logic         miner_ready,
   output logic [31:0]  miner_serial_in,
   input  logic         miner_hit,
   input  logic [31:0]  miner_serial_out,
   output logic         result_valid,
   input  logic         result_ready,
   output logic         result_found,
   output logic [31:0]  result_nonce,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, REPORT} state_t;

`ifdef NONCE_CORR_EN
   localparam bit CORR_EN = 1'b1;
`else
   localparam bit CORR_EN = 1'b0;
`endif

   state_t        state, next_state;
   logic [3:0]    k;          // index of the word currently on miner_serial_in
   logic [319:0]  shreg;      // words still to be sent, next one in the top 32 bits
   logic [39:0]   scan_cnt;
   logic          accept, hit_seen, timeout, last_word;
   logic [31:0]   hit_nonce;

   assign accept    = work_valid & work_ready;
   assign last_word = (k == 4'd10);
   assign hit_nonce = CORR_EN ? (miner_serial_out - NONCE_OFFSET) : miner_serial_out;

   // State register
   always_ff @(posedge hash_clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state logic; a hit outranks a timeout in the same cycle
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = LOAD;
         LOAD:    if (last_word) next_state = RUN;
         RUN:     if (hit_seen || timeout) next_state = REPORT;
                  else if (accept) next_state = LOAD;
         REPORT:  if (result_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Output/decode logic. The first two RUN cycles ignore miner_hit because the miner
   // pipeline may still hold a stale flag from the previous job.
   always_comb begin
      hit_seen   = (state == RUN) && miner_hit && (scan_cnt >= 40'd2);
      timeout    = (state == RUN) && (scan_cnt == SCAN_CYCLES - 40'd1);
      work_ready = (state == IDLE) || ((state == RUN) && !miner_hit && !timeout);
   end

   // Registered outputs and datapath
   always_ff @(posedge hash_clk) begin
      if (!rst_n) begin
         k               <= 4'd0;
         shreg           <= '0;
         scan_cnt        <= 40'd0;
         miner_ready     <= 1'b0;
         miner_serial_in <= 32'd0;
         result_valid    <= 1'b0;
         result_found    <= 1'b0;
         result_nonce    <= 32'd0;
         busy            <= 1'b0;
      end else begin
         miner_ready <= (next_state == LOAD);
         busy        <= (next_state != IDLE);

         // Word 0 goes out on the edge that accepts the job (also on preemption)
         if (accept) begin
            miner_serial_in <= work_data[351:320];
            shreg           <= work_data[319:0];
            k               <= 4'd0;
         end else if (state == LOAD) begin
            if (last_word) begin
               miner_serial_in <= 32'd0;
            end else begin
               miner_serial_in <= shreg[319:288];
               shreg           <= {shreg[287:0], 32'd0};
               k               <= k + 4'd1;
            end
         end

         // Held at zero during LOAD so it starts from 0 on the first RUN cycle
         if (state == LOAD)     scan_cnt <= 40'd0;
         else if (state == RUN) scan_cnt <= scan_cnt + 40'd1;

         if ((state == RUN) && (hit_seen || timeout)) begin
            result_valid <= 1'b1;
            result_found <= hit_seen;
            result_nonce <= hit_seen ? hit_nonce : 32'd0;
         end else if ((state == REPORT) && result_ready) begin
            result_valid <= 1'b0;
            result_found <= 1'b0;
            result_nonce <= 32'd0;
         end
      end
   end

endmodule

// File: tb/tb_miner_work_feeder.sv
// tb/tb_miner_work_feeder.sv - randomized self-checking bench for miner_work_feeder

module tb_miner_work_feeder;

   localparam logic [39:0] SCAN = 40'd100;
   localparam logic [31:0] OFFS = 32'd131;

   logic         hash_clk;
   logic         rst_n;
   logic         work_valid;
   logic         work_ready;
   logic [351:0] work_data;
   logic         miner_ready;
   logic [31:0]  miner_serial_in;
   logic         miner_hit;
   logic [31:0]  miner_serial_out;
   logic         result_valid;
   logic         result_ready;
   logic         result_found;
   logic [31:0]  result_nonce;
   logic         busy;

   miner_work_feeder #(
      .LOOP_LOG2   (0),
      .SCAN_CYCLES (SCAN),
      .NONCE_OFFSET(OFFS)
   ) dut (
      .hash_clk        (hash_clk),
      .rst_n           (rst_n),
      .work_valid      (work_valid),
      .work_ready      (work_ready),
      .work_data       (work_data),
      .miner_ready     (miner_ready),
      .miner_serial_in (miner_serial_in),
      .miner_hit       (miner_hit),
      .miner_serial_out(miner_serial_out),
      .result_valid    (result_valid),
      .result_ready    (result_ready),
      .result_found    (result_found),
      .result_nonce    (result_nonce),
      .busy            (busy)
   );

   initial hash_clk = 1'b0;
   always #5 hash_clk = ~hash_clk;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] job_w [11];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      else n_pass++;
   endtask

   task automatic fill_seq();
      for (int i = 0; i < 11; i++) job_w[i] = 32'(i + 1);
   endtask

   task automatic fill_random();
      for (int i = 0; i < 11; i++) job_w[i] = $urandom;
   endtask

   // Offer the current job at a negedge; it must be taken on the next posedge
   task automatic offer();
      logic [351:0] d;
      d = '0;
      for (int i = 0; i < 11; i++) d = {d[319:0], job_w[i]};
      work_data  = d;
      work_valid = 1'b1;
      miner_hit  = 1'b0;
      chk("offer_work_ready", 64'(work_ready), 64'd1);
      @(negedge hash_clk);
      work_valid = 1'b0;
   endtask

   task automatic expect_load();
      for (int i = 0; i < 11; i++) begin
         chk("load_strobe", 64'(miner_ready), 64'd1);
         chk("load_word", 64'(miner_serial_in), 64'(job_w[i]));
         chk("load_work_ready", 64'(work_ready), 64'd0);
         chk("load_no_result", 64'(result_valid), 64'd0);
         @(negedge hash_clk);
      end
      chk("run_strobe_off", 64'(miner_ready), 64'd0);
      chk("run_word_zero", 64'(miner_serial_in), 64'd0);
      chk("run_busy", 64'(busy), 64'd1);
   endtask

   // Reference: the hit is honoured from RUN cycle 2 onward; the job times out in RUN
   // cycle SCAN-1; a hit in that same cycle still counts as found.
   task automatic expect_run(input int hit_at, input logic [31:0] nonce, input int hold);
      int          eff, exp_c, c;
      logic        exp_found;
      logic [31:0] exp_nonce;
      eff = (hit_at < 2) ? 2 : hit_at;
      if (eff <= int'(SCAN) - 1) begin
         exp_found = 1'b1;
         exp_c     = eff;
`ifdef NONCE_CORR_EN
         exp_nonce = nonce - OFFS;
`else
         exp_nonce = nonce;
`endif
      end else begin
         exp_found = 1'b0;
         exp_c     = int'(SCAN) - 1;
         exp_nonce = 32'd0;
      end
      c = 0;
      while (!result_valid && c < 200) begin
         if (c >= hit_at) begin
            miner_hit        = 1'b1;
            miner_serial_out = nonce;
         end else begin
            miner_hit        = 1'b0;
            miner_serial_out = $urandom;
         end
         @(negedge hash_clk);
         c++;
      end
      chk("result_latency", 64'(c), 64'(exp_c + 1));
      chk("result_valid", 64'(result_valid), 64'd1);
      chk("result_found", 64'(result_found), 64'(exp_found));
      chk("result_nonce", 64'(result_nonce), 64'(exp_nonce));
      chk("report_work_ready", 64'(work_ready), 64'd0);
      result_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(negedge hash_clk);
         chk("hold_valid", 64'(result_valid), 64'd1);
         chk("hold_found", 64'(result_found), 64'(exp_found));
         chk("hold_nonce", 64'(result_nonce), 64'(exp_nonce));
         chk("hold_work_ready", 64'(work_ready), 64'd0);
      end
      result_ready = 1'b1;
      @(negedge hash_clk);
      result_ready = 1'b0;
      chk("release_valid", 64'(result_valid), 64'd0);
      chk("release_busy", 64'(busy), 64'd0);
      chk("release_work_ready", 64'(work_ready), 64'd1);
   endtask

   initial begin
      rst_n            = 1'b0;
      work_valid       = 1'b0;
      work_data        = '0;
      result_ready     = 1'b0;
      miner_hit        = 1'b0;
      miner_serial_out = 32'd0;
      repeat (3) @(negedge hash_clk);
      chk("rst_miner_ready", 64'(miner_ready), 64'd0);
      chk("rst_serial_in", 64'(miner_serial_in), 64'd0);
      chk("rst_result_valid", 64'(result_valid), 64'd0);
      chk("rst_result_found", 64'(result_found), 64'd0);
      chk("rst_result_nonce", 64'(result_nonce), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      @(negedge hash_clk);

      // Load order 1..11, then a hit 20 RUN cycles in
      fill_seq();
      offer();
      expect_load();
      expect_run(20, 32'h0000_01A0, 0);

      // Exhaustion, hit coinciding with timeout, hit inside the ignore window
      fill_random(); offer(); expect_load(); expect_run(1000, 32'd0, 2);
      fill_random(); offer(); expect_load(); expect_run(99, $urandom, 0);
      fill_random(); offer(); expect_load(); expect_run(100, $urandom, 0);
      fill_random(); offer(); expect_load(); expect_run(0, $urandom, 1);

      // Backpressure for 50 cycles, then a back-to-back job
      fill_random(); offer(); expect_load(); expect_run(10, $urandom, 50);

      // Preemption 30 cycles into RUN
      fill_random(); offer(); expect_load();
      for (int c = 0; c < 30; c++) begin
         miner_hit        = 1'b0;
         miner_serial_out = $urandom;
         @(negedge hash_clk);
      end
      fill_random();
      offer();
      expect_load();
      expect_run(40, $urandom, 0);

      // Reset while the word with k=5 is on the port
      fill_random(); offer();
      for (int i = 0; i < 5; i++) @(negedge hash_clk);
      chk("k5_word", 64'(miner_serial_in), 64'(job_w[5]));
      rst_n = 1'b0;
      @(negedge hash_clk);
      chk("mid_rst_strobe", 64'(miner_ready), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_idle", 64'(work_ready), 64'd1);
      chk("mid_rst_word", 64'(miner_serial_in), 64'd0);
      rst_n = 1'b1;
      @(negedge hash_clk);
      fill_random(); offer(); expect_load(); expect_run(5, $urandom, 0);

      // Randomized jobs
      for (int j = 0; j < 8; j++) begin
         fill_random();
         offer();
         expect_load();
         expect_run(int'($urandom_range(0, 110)), $urandom, int'($urandom_range(0, 4)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
